conv1x1_seq_ctrl: RTL and testbench
===================================

Name: conv1x1_seq_ctrl

Overview:
- Sequencer for a time-multiplexed 1x1 convolution: one multiply-accumulate unit walks every (out channel, output pixel, in channel) triple.
- Reads input, weight and bias from external synchronous memories with 1-cycle read latency.
- Streams each finished output element over a valid/ready port.
- Sits between the tensor buffers and downstream layers; it is the low-area alternative to the fully parallel flat-bus conv1x1 datapath, and uses the same tensor layout.

Parameters:
- DATA_WIDTH, 32, width of every tensor element, weight, bias and accumulator (two's complement).
- IN_CHANNELS, 1, input channels.
- OUT_CHANNELS, 1, output channels.
- IN_HEIGHT, 4, input rows.
- IN_WIDTH, 4, input columns.
- STRIDE, 1, spatial stride (>=1). Derived: OUT_HEIGHT=(IN_HEIGHT-1)/STRIDE+1, OUT_WIDTH=(IN_WIDTH-1)/STRIDE+1.
- ADDR_WIDTH, 16, width of all address ports.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  1-cycle pulse; begins one full layer pass.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  1-cycle pulse after the last output handshake.
- in_rd_en  out  1  input memory read strobe.
- in_rd_addr  out  ADDR_WIDTH  ic*IN_HEIGHT*IN_WIDTH + oh*STRIDE*IN_WIDTH + ow*STRIDE.
- in_rd_data  in  DATA_WIDTH  valid the cycle after in_rd_en.
- w_rd_en  out  1  weight read strobe.
- w_rd_addr  out  ADDR_WIDTH  oc*IN_CHANNELS + ic.
- w_rd_data  in  DATA_WIDTH  valid the cycle after w_rd_en.
- b_rd_en  out  1  bias read strobe.
- b_rd_addr  out  ADDR_WIDTH  oc.
- b_rd_data  in  DATA_WIDTH  valid the cycle after b_rd_en.
- out_valid  out  1  output element available.
- out_ready  in  1  downstream accepts.
- out_data  out  DATA_WIDTH  result element.
- out_idx  out  ADDR_WIDTH  oc*OUT_HEIGHT*OUT_WIDTH + oh*OUT_WIDTH + ow.

Behaviour:
- Reset (rst low, asynchronous): state=IDLE; all counters, accumulator, busy, done, every rd_en, out_valid, out_data, out_idx and addresses =0.
- Loop order, outermost to innermost: oc, oh, ow, ic.
- IDLE: start=1 -> BIAS; counters cleared; busy=1 next cycle. start while not IDLE is ignored.
- BIAS (1 cycle): b_rd_en=1 for current oc -> MAC.
- MAC (IN_CHANNELS cycles, k=0..IN_CHANNELS-1): in cycle k, assert in_rd_en/w_rd_en for ic=k.
- MAC accumulate: cycle 0 does acc<=b_rd_data; cycle k>=1 does acc<=acc+in_rd_data*w_rd_data (product of ic=k-1). After the last k -> DRAIN.
- DRAIN (1 cycle): accumulate the last product -> OUT.
- OUT: out_valid=1; out_data and out_idx are registered and held stable while out_ready=0.
- OUT on handshake (valid&ready): if not the last element, advance ow/oh/oc with wrap (ow wraps to 0 and increments oh; oh wraps and increments oc) -> BIAS; else -> DONE.
- DONE (1 cycle): done=1, busy=0 -> IDLE.
- Throughput: IN_CHANNELS+3 cycles per output element with out_ready held high. Full pass takes OUT_CHANNELS*OUT_HEIGHT*OUT_WIDTH*(IN_CHANNELS+3)+1 cycles from the start cycle to the done pulse.
- Arithmetic: signed multiply, product truncated to the low DATA_WIDTH bits. Accumulation is modulo 2^DATA_WIDTH (wrap, no saturation).
- rd_en strobes are high only in their named states; addresses are don't-care otherwise but held at their last value.
- Reset mid-pass: immediate return to IDLE. No done pulse; the partial pass is discarded.
- out_ready high outside OUT has no effect.

Optional Feature:
- CONV1X1_RELU_EN defined: out_data = (acc<0) ? 0 : acc, applied at entry to OUT.
- Undefined: out_data = acc unmodified. Timing is identical in both cases.

Test Plan:
- Default params; input 0..15, weight 2, bias 1; out_ready=1; start pulse -> 16 outputs, idx 0..15, data 1,3,5,...,31; done exactly 65 cycles after start; busy low afterwards.
- Same stimulus, out_ready toggled with pattern 1,0,0,1 -> identical data/idx sequence; out_data stable during every stall; no element lost or duplicated.
- IN_CHANNELS=2, OUT_CHANNELS=2, 2x2 input; ch0=1,2,3,4, ch1=10,20,30,40; w={1,1,2,-1}; b={0,5} -> oc0 outputs 11,22,33,44; oc1 outputs -3,-11,-19,-27 (with CONV1X1_RELU_EN: 0,0,0,0).
- STRIDE=2, 4x4 input 0..15, weight 1, bias 0 -> 4 outputs with data 0,2,8,10 and idx 0..3.
- Deassert rst mid-pass during a stall in OUT, then release and pulse start -> all outputs zero during reset, no done pulse; the new pass produces the full correct sequence from idx 0.
- start asserted again while busy -> ignored; exactly 16 outputs and one done pulse.

Source files
------------

// File: rtl/conv1x1_seq_ctrl.sv
// Time-multiplexed 1x1 convolution sequencer: one MAC walks (oc, oh, ow, ic) over external 1-cycle-latency memories.
// Optional ReLU on the output element when CONV1X1_RELU_EN is defined.
module conv1x1_seq_ctrl #(
  parameter int DATA_WIDTH   = 32,
  parameter int IN_CHANNELS  = 1,
  parameter int OUT_CHANNELS = 1,
  parameter int IN_HEIGHT    = 4,
  parameter int IN_WIDTH     = 4,
  parameter int STRIDE       = 1,
  parameter int ADDR_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  in_rd_en,
  output logic [ADDR_WIDTH-1:0] in_rd_addr,
  input  logic [DATA_WIDTH-1:0] in_rd_data,
  output logic                  w_rd_en,
  output logic [ADDR_WIDTH-1:0] w_rd_addr,
  input  logic [DATA_WIDTH-1:0] w_rd_data,
  output logic                  b_rd_en,
  output logic [ADDR_WIDTH-1:0] b_rd_addr,
  input  logic [DATA_WIDTH-1:0] b_rd_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0] out_idx
);
  localparam int OUT_HEIGHT = (IN_HEIGHT - 1) / STRIDE + 1;
  localparam int OUT_WIDTH  = (IN_WIDTH - 1) / STRIDE + 1;
  localparam int AW = ADDR_WIDTH;
  localparam int DW = DATA_WIDTH;

  typedef enum logic [2:0] {S_IDLE, S_BIAS, S_MAC, S_DRAIN, S_OUT, S_DONE} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   oc_q, oc_d, oh_q, oh_d, ow_q, ow_d, ic_q, ic_d;
  logic [DW-1:0]   acc_q, acc_d, out_data_q, out_data_d;
  logic [AW-1:0]   out_idx_q, out_idx_d;
  logic [AW-1:0]   in_addr_q, w_addr_q, b_addr_q;
  logic [AW-1:0]   in_addr_cur, w_addr_cur, idx_cur;
  logic [DW-1:0]   prod, acc_sum, res;
  logic            last_ow, last_oh, last_oc;

  // Low DW bits of a two's complement product do not depend on signedness.
  assign prod    = in_rd_data * w_rd_data;
  assign acc_sum = acc_q + prod;

`ifdef CONV1X1_RELU_EN
  assign res = acc_sum[DW-1] ? '0 : acc_sum;
`else
  assign res = acc_sum;
`endif

  assign in_addr_cur = ic_q * AW'(IN_HEIGHT * IN_WIDTH) + oh_q * AW'(STRIDE * IN_WIDTH)
                     + ow_q * AW'(STRIDE);
  assign w_addr_cur  = oc_q * AW'(IN_CHANNELS) + ic_q;
  assign idx_cur     = oc_q * AW'(OUT_HEIGHT * OUT_WIDTH) + oh_q * AW'(OUT_WIDTH) + ow_q;

  assign last_ow = (ow_q == AW'(OUT_WIDTH - 1));
  assign last_oh = (oh_q == AW'(OUT_HEIGHT - 1));
  assign last_oc = (oc_q == AW'(OUT_CHANNELS - 1));

  assign busy      = (state_q == S_BIAS) || (state_q == S_MAC) ||
                     (state_q == S_DRAIN) || (state_q == S_OUT);
  assign done      = (state_q == S_DONE);
  assign out_valid = (state_q == S_OUT);
  assign out_data  = out_data_q;
  assign out_idx   = out_idx_q;
  assign b_rd_en   = (state_q == S_BIAS);
  assign in_rd_en  = (state_q == S_MAC);
  assign w_rd_en   = (state_q == S_MAC);

  // Addresses follow the counters while strobing and hold their last value otherwise.
  assign b_rd_addr  = b_rd_en  ? oc_q        : b_addr_q;
  assign in_rd_addr = in_rd_en ? in_addr_cur : in_addr_q;
  assign w_rd_addr  = w_rd_en  ? w_addr_cur  : w_addr_q;

  always_comb begin
    state_d    = state_q;
    oc_d       = oc_q;
    oh_d       = oh_q;
    ow_d       = ow_q;
    ic_d       = ic_q;
    acc_d      = acc_q;
    out_data_d = out_data_q;
    out_idx_d  = out_idx_q;
    case (state_q)
      S_IDLE: if (start) begin
        state_d = S_BIAS;
        oc_d = '0; oh_d = '0; ow_d = '0; ic_d = '0;
      end
      S_BIAS: begin
        ic_d    = '0;
        state_d = S_MAC;
      end
      S_MAC: begin
        acc_d = (ic_q == '0) ? b_rd_data : acc_sum;
        if (ic_q == AW'(IN_CHANNELS - 1)) state_d = S_DRAIN;
        else                               ic_d    = ic_q + 1'b1;
      end
      S_DRAIN: begin
        acc_d      = acc_sum;
        out_data_d = res;
        out_idx_d  = idx_cur;
        state_d    = S_OUT;
      end
      S_OUT: if (out_ready) begin
        if (last_ow && last_oh && last_oc) begin
          state_d = S_DONE;
        end else begin
          state_d = S_BIAS;
          ow_d    = last_ow ? '0 : ow_q + 1'b1;
          if (last_ow) begin
            oh_d = last_oh ? '0 : oh_q + 1'b1;
            if (last_oh) oc_d = oc_q + 1'b1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      oc_q       <= '0;
      oh_q       <= '0;
      ow_q       <= '0;
      ic_q       <= '0;
      acc_q      <= '0;
      out_data_q <= '0;
      out_idx_q  <= '0;
      in_addr_q  <= '0;
      w_addr_q   <= '0;
      b_addr_q   <= '0;
    end else begin
      state_q    <= state_d;
      oc_q       <= oc_d;
      oh_q       <= oh_d;
      ow_q       <= ow_d;
      ic_q       <= ic_d;
      acc_q      <= acc_d;
      out_data_q <= out_data_d;
      out_idx_q  <= out_idx_d;
      if (in_rd_en) in_addr_q <= in_addr_cur;
      if (w_rd_en)  w_addr_q  <= w_addr_cur;
      if (b_rd_en)  b_addr_q  <= oc_q;
    end
  end
endmodule

// File: tb/tb_conv1x1_seq_ctrl.sv
// Bench for conv1x1_seq_ctrl: a default-geometry instance and a 2-in/2-out-channel stride-2 instance,
// sharing start/ready/reset, each checked against a loop-nest reference model.
module tb_conv1x1_seq_ctrl;
  localparam int DW = 32, AW = 16;
  localparam int B_IC = 2, B_OC = 2, B_IH = 4, B_IW = 4, B_S = 2;
  localparam int B_OH = (B_IH - 1) / B_S + 1, B_OW = (B_IW - 1) / B_S + 1;

  logic clk = 1'b0;
  logic rst, start, out_ready;
  always #5 clk = ~clk;

  logic a_busy, a_done, a_in_en, a_w_en, a_b_en, a_vld;
  logic [AW-1:0] a_in_addr, a_w_addr, a_b_addr, a_idx;
  logic [DW-1:0] a_in_d, a_w_d, a_b_d, a_data;
  logic b_busy, b_done, b_in_en, b_w_en, b_b_en, b_vld;
  logic [AW-1:0] b_in_addr, b_w_addr, b_b_addr, b_idx;
  logic [DW-1:0] b_in_d, b_w_d, b_b_d, b_data;

  logic [DW-1:0] a_in_m [16];
  logic [DW-1:0] a_w_m  [1];
  logic [DW-1:0] a_b_m  [1];
  logic [DW-1:0] b_in_m [B_IC*B_IH*B_IW];
  logic [DW-1:0] b_w_m  [B_OC*B_IC];
  logic [DW-1:0] b_b_m  [B_OC];

  logic [DW-1:0] expa_d[$], expb_d[$];
  int            expa_i[$], expb_i[$];
  int n_vec = 0, n_err = 0;

  conv1x1_seq_ctrl u_a (
    .clk(clk), .rst(rst), .start(start), .busy(a_busy), .done(a_done),
    .in_rd_en(a_in_en), .in_rd_addr(a_in_addr), .in_rd_data(a_in_d),
    .w_rd_en(a_w_en), .w_rd_addr(a_w_addr), .w_rd_data(a_w_d),
    .b_rd_en(a_b_en), .b_rd_addr(a_b_addr), .b_rd_data(a_b_d),
    .out_valid(a_vld), .out_ready(out_ready), .out_data(a_data), .out_idx(a_idx));

  conv1x1_seq_ctrl #(.IN_CHANNELS(B_IC), .OUT_CHANNELS(B_OC), .IN_HEIGHT(B_IH),
                     .IN_WIDTH(B_IW), .STRIDE(B_S)) u_b (
    .clk(clk), .rst(rst), .start(start), .busy(b_busy), .done(b_done),
    .in_rd_en(b_in_en), .in_rd_addr(b_in_addr), .in_rd_data(b_in_d),
    .w_rd_en(b_w_en), .w_rd_addr(b_w_addr), .w_rd_data(b_w_d),
    .b_rd_en(b_b_en), .b_rd_addr(b_b_addr), .b_rd_data(b_b_d),
    .out_valid(b_vld), .out_ready(out_ready), .out_data(b_data), .out_idx(b_idx));

  // 1-cycle-latency memories; out-of-range reads return a marker value
  always @(posedge clk) begin
    if (a_in_en) a_in_d <= (int'(a_in_addr) < 16) ? a_in_m[int'(a_in_addr)] : 32'hDEAD_BEEF;
    if (a_w_en)  a_w_d  <= (int'(a_w_addr) < 1)   ? a_w_m[0]  : 32'hDEAD_BEEF;
    if (a_b_en)  a_b_d  <= (int'(a_b_addr) < 1)   ? a_b_m[0]  : 32'hDEAD_BEEF;
    if (b_in_en) b_in_d <= (int'(b_in_addr) < B_IC*B_IH*B_IW) ? b_in_m[int'(b_in_addr)] : 32'hDEAD_BEEF;
    if (b_w_en)  b_w_d  <= (int'(b_w_addr) < B_OC*B_IC) ? b_w_m[int'(b_w_addr)] : 32'hDEAD_BEEF;
    if (b_b_en)  b_b_d  <= (int'(b_b_addr) < B_OC) ? b_b_m[int'(b_b_addr)] : 32'hDEAD_BEEF;
  end

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] relu(input logic [DW-1:0] v);
`ifdef CONV1X1_RELU_EN
    return v[DW-1] ? '0 : v;
`else
    return v;
`endif
  endfunction

  // Reference: plain loop nest, output index is simply the position in the stream.
  task automatic build_exp();
    logic [DW-1:0] acc;
    int n;
    expa_d.delete(); expa_i.delete(); expb_d.delete(); expb_i.delete();
    n = 0;
    for (int oh = 0; oh < 4; oh++)
      for (int ow = 0; ow < 4; ow++) begin
        acc = a_b_m[0] + a_in_m[oh*4 + ow] * a_w_m[0];
        expa_d.push_back(relu(acc)); expa_i.push_back(n); n++;
      end
    n = 0;
    for (int oc = 0; oc < B_OC; oc++)
      for (int oh = 0; oh < B_OH; oh++)
        for (int ow = 0; ow < B_OW; ow++) begin
          acc = b_b_m[oc];
          for (int ic = 0; ic < B_IC; ic++)
            acc = acc + b_in_m[ic*B_IH*B_IW + oh*B_S*B_IW + ow*B_S] * b_w_m[oc*B_IC + ic];
          expb_d.push_back(relu(acc)); expb_i.push_back(n); n++;
        end
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_busy"}, {30'd0, a_busy, b_busy}, 0);
    chk({tag, "_done"}, {30'd0, a_done, b_done}, 0);
    chk({tag, "_vld"},  {30'd0, a_vld, b_vld}, 0);
    chk({tag, "_en"},   {26'd0, a_in_en, a_w_en, a_b_en, b_in_en, b_w_en, b_b_en}, 0);
    chk({tag, "_adata"}, a_data, 0);
    chk({tag, "_bdata"}, b_data, 0);
    chk({tag, "_idx"},  {a_idx, b_idx}, 0);
    chk({tag, "_addr"}, {a_in_addr | a_w_addr | a_b_addr, b_in_addr | b_w_addr | b_b_addr}, 0);
  endtask

  // rmode: 0 ready always, 1 pattern 1,0,0,1, 2 random
  task automatic run_pass(input int rmode, input bit poke_start, input bit chk_lat);
    int qa, qb, da, db, dca, dcb;
    bit pva, pvb, pha, phb, ha, hb;
    logic [DW-1:0] pda, pdb;
    logic [AW-1:0] pia, pib;
    build_exp();
    qa = 0; qb = 0; da = 0; db = 0; dca = -1; dcb = -1;
    pva = 0; pvb = 0; pha = 0; phb = 0; pda = '0; pdb = '0; pia = '0; pib = '0;
    @(negedge clk); start = 1'b1; out_ready = 1'b0;
    for (int n = 1; n < 600; n++) begin
      @(negedge clk);
      start = poke_start && (n == 7);
      case (rmode)
        0:       out_ready = 1'b1;
        1:       out_ready = ((n - 1) % 4 == 0) || ((n - 1) % 4 == 3);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (a_done) begin da++; dca = n; end
      if (b_done) begin db++; dcb = n; end
      chk("a_busy", {31'd0, a_busy}, {31'd0, dca < 0});
      chk("b_busy", {31'd0, b_busy}, {31'd0, dcb < 0});
      if (a_vld && pva && !pha) begin chk("a_stall_d", a_data, pda); chk("a_stall_i", a_idx, pia); end
      if (b_vld && pvb && !phb) begin chk("b_stall_d", b_data, pdb); chk("b_stall_i", b_idx, pib); end
      ha = a_vld && out_ready;
      hb = b_vld && out_ready;
      if (ha) begin
        if (qa < expa_d.size()) begin
          chk("a_data", a_data, expa_d[qa]); chk("a_idx", a_idx, AW'(expa_i[qa]));
        end else chk("a_extra", qa, expa_d.size() - 1);
        qa++;
      end
      if (hb) begin
        if (qb < expb_d.size()) begin
          chk("b_data", b_data, expb_d[qb]); chk("b_idx", b_idx, AW'(expb_i[qb]));
        end else chk("b_extra", qb, expb_d.size() - 1);
        qb++;
      end
      pva = a_vld; pha = ha; pda = a_data; pia = a_idx;
      pvb = b_vld; phb = hb; pdb = b_data; pib = b_idx;
      if (dca >= 0 && dcb >= 0) break;
    end
    chk("a_ndone", da, 1);
    chk("b_ndone", db, 1);
    chk("a_count", qa, expa_d.size());
    chk("b_count", qb, expb_d.size());
    if (chk_lat) begin
      chk("a_lat", dca, 16 * 4 + 1);
      chk("b_lat", dcb, B_OC * B_OH * B_OW * (B_IC + 3) + 1);
    end
    @(negedge clk);
    chk("post_busy", {30'd0, a_busy, b_busy}, 0);
    chk("post_done", {30'd0, a_done, b_done}, 0);
  endtask

  task automatic run_reset();
    int n;
    @(negedge clk); start = 1'b1; out_ready = 1'b0;
    @(negedge clk); start = 1'b0;
    n = 0;
    while (!a_vld && n < 50) begin @(negedge clk); n++; end
    chk("rs_reach", {31'd0, a_vld}, 1);
    @(negedge clk);
    rst = 1'b0; #1;
    chk_idle_zero("rs_in");
    repeat (3) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rs_after", {28'd0, a_done, b_done, a_busy, b_busy}, 0);
    end
  endtask

  task automatic fill_directed();
    for (int i = 0; i < 16; i++) a_in_m[i] = DW'(i);
    a_w_m[0] = 2; a_b_m[0] = 1;
    for (int i = 0; i < 16; i++) begin b_in_m[i] = DW'(i); b_in_m[16 + i] = DW'(10 * (i + 1)); end
    b_w_m[0] = 1; b_w_m[1] = 1; b_w_m[2] = 2; b_w_m[3] = -1;
    b_b_m[0] = 0; b_b_m[1] = 5;
  endtask

  task automatic fill_random();
    for (int i = 0; i < 16; i++) a_in_m[i] = $urandom;
    a_w_m[0] = $urandom; a_b_m[0] = $urandom;
    for (int i = 0; i < B_IC*B_IH*B_IW; i++) b_in_m[i] = $urandom;
    for (int i = 0; i < B_OC*B_IC; i++) b_w_m[i] = $urandom;
    for (int i = 0; i < B_OC; i++) b_b_m[i] = $urandom;
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; out_ready = 1'b0;
    fill_directed();
    repeat (3) @(negedge clk);
    chk_idle_zero("reset");
    rst = 1'b1;
    @(negedge clk);
    run_pass(0, 1'b0, 1'b1);
    run_pass(1, 1'b0, 1'b0);
    run_pass(0, 1'b1, 1'b1);
    run_reset();
    run_pass(0, 1'b0, 1'b1);
    for (int r = 0; r < 4; r++) begin
      fill_random();
      run_pass((r == 0) ? 0 : 2, 1'b0, r == 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
